// File: rtl/quad_updn_decoder_pkg.sv
// Shared encodings for the quadrature decoder: Gray-code AB states,
// step directions, FSM states, and the step classification function.
package quad_updn_decoder_pkg;

   localparam logic [1:0] AB_00 = 2'b00;
   localparam logic [1:0] AB_10 = 2'b10;
   localparam logic [1:0] AB_11 = 2'b11;
   localparam logic [1:0] AB_01 = 2'b01;

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_UP   = 2'd1,
      STEP_DN   = 2'd2,
      STEP_ERR  = 2'd3
   } step_t;

   typedef enum logic {
      PRIME = 1'b0,
      TRACK = 1'b1
   } fsm_t;

   // Forward successor along 00 -> 10 -> 11 -> 01 -> 00
   function automatic logic [1:0] next_up(input logic [1:0] ab);
      logic [1:0] nxt;
      case (ab)
         AB_00:   nxt = AB_10;
         AB_10:   nxt = AB_11;
         AB_11:   nxt = AB_01;
         default: nxt = AB_00;
      endcase
      return nxt;
   endfunction

   function automatic step_t step_dir(input logic [1:0] prev, input logic [1:0] cur);
      step_t dir;
      if (cur == prev)
         dir = STEP_NONE;
      else if (cur == next_up(prev))
         dir = STEP_UP;
      else if (prev == next_up(cur))
         dir = STEP_DN;
      else
         dir = STEP_ERR;
      return dir;
   endfunction

endpackage

// File: rtl/quad_updn_decoder_filter.sv
// One-bit input conditioner: SYNC_STAGES-deep synchronizer followed by a
// stability filter that accepts a new level only after FILT steady samples.
module quad_input_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT        = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout,
   output logic settled
);

   localparam int CW = $clog2(FILT + 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   filt_q, filt_d;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   // A one-bit sample that differs from the filtered level can only equal the
   // previous sample or the filtered level itself (count already zero), so a
   // plain run counter of differing samples implements the stability rule.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
      cnt_d  = '0;
      filt_d = filt_q;
      if (s != filt_q) begin
         if (cnt_q == CW'(FILT - 1)) begin
            filt_d = s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign dout    = filt_q;
   assign settled = (sync_q == {SYNC_STAGES{filt_q}});

endmodule

// File: rtl/quad_updn_decoder.sv
// Quadrature up/down decoder: filtered A/B inputs, Gray-step decode into
// one-cycle up/down pulses, and an N-bit position count with carry/borrow.
module quad_updn_decoder
   import quad_updn_decoder_pkg::*;
#(
   parameter int N           = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILT        = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ina,
   input  logic         inb,
   input  logic         clr,
   output logic         up_pulse,
   output logic         dn_pulse,
   output logic [N-1:0] pos,
   output logic         cout,
   output logic         bout,
   output logic         err
);

   localparam int PCW = $clog2(FILT + 1);

   logic        filt_a, filt_b;
   logic        settled_a, settled_b;
   logic        both_settled;
   logic [1:0]  ab;
   step_t       dir;

   fsm_t           state_q, state_d;
   logic [1:0]     prev_ab_q, prev_ab_d;
   logic [PCW-1:0] prime_cnt_q, prime_cnt_d;
   logic [N-1:0]   pos_q, pos_d;
   logic           up_q, up_d;
   logic           dn_q, dn_d;
   logic           cout_q, cout_d;
   logic           bout_q, bout_d;
   logic           err_q, err_d;

   quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT(FILT)) u_filt_a (
      .clk     (clk),
      .reset   (reset),
      .din     (ina),
      .dout    (filt_a),
      .settled (settled_a)
   );

   quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT(FILT)) u_filt_b (
      .clk     (clk),
      .reset   (reset),
      .din     (inb),
      .dout    (filt_b),
      .settled (settled_b)
   );

   assign ab           = {filt_a, filt_b};
   assign both_settled = settled_a & settled_b;

   always_comb begin
      state_d     = state_q;
      prev_ab_d   = prev_ab_q;
      prime_cnt_d = prime_cnt_q;
      pos_d       = pos_q;
      up_d        = 1'b0;
      dn_d        = 1'b0;
      cout_d      = 1'b0;
      bout_d      = 1'b0;
      err_d       = 1'b0;
      dir         = step_dir(prev_ab_q, ab);

      case (state_q)
         PRIME: begin
            // Prime on the first accepted level, or once both inputs have sat
            // quietly for FILT cycles (encoder parked at 00).
            prime_cnt_d = both_settled ? prime_cnt_q + 1'b1 : '0;
            if ((ab != AB_00) || (both_settled && (prime_cnt_q == PCW'(FILT - 1)))) begin
               prev_ab_d   = ab;
               prime_cnt_d = '0;
               state_d     = TRACK;
            end
         end
         default: begin
            prev_ab_d = ab;
            case (dir)
               STEP_UP: begin
                  up_d   = 1'b1;
                  pos_d  = pos_q + 1'b1;
                  cout_d = &pos_q;
               end
               STEP_DN: begin
                  dn_d   = 1'b1;
                  pos_d  = pos_q - 1'b1;
                  bout_d = ~|pos_q;
               end
               STEP_ERR: err_d = 1'b1;
               default: ;
            endcase
         end
      endcase

      if (clr) begin
         pos_d  = '0;
         cout_d = 1'b0;
         bout_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= PRIME;
         prev_ab_q   <= AB_00;
         prime_cnt_q <= '0;
         pos_q       <= '0;
         up_q        <= 1'b0;
         dn_q        <= 1'b0;
         cout_q      <= 1'b0;
         bout_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_ab_q   <= prev_ab_d;
         prime_cnt_q <= prime_cnt_d;
         pos_q       <= pos_d;
         up_q        <= up_d;
         dn_q        <= dn_d;
         cout_q      <= cout_d;
         bout_q      <= bout_d;
         err_q       <= err_d;
      end
   end

   assign up_pulse = up_q;
   assign dn_pulse = dn_q;
   assign pos      = pos_q;
   assign cout     = cout_q;
   assign bout     = bout_q;
   assign err      = err_q;

endmodule

// File: tb/tb_quad_updn_decoder.sv
// Bench for quad_updn_decoder: directed scenarios plus random encoder traffic,
// compared every cycle against a history-based behavioural model.
module tb_quad_updn_decoder;

   localparam int N  = 8;
   localparam int SS = 2;
   localparam int FL = 3;

   logic         clk = 1'b0;
   logic         reset;
   logic         ina, inb, clr;
   logic         up_pulse, dn_pulse, cout, bout, err;
   logic [N-1:0] pos;

   int checks   = 0;
   int failures = 0;

   quad_updn_decoder #(.N(N), .SYNC_STAGES(SS), .FILT(FL)) dut (
      .clk      (clk),
      .reset    (reset),
      .ina      (ina),
      .inb      (inb),
      .clr      (clr),
      .up_pulse (up_pulse),
      .dn_pulse (dn_pulse),
      .pos      (pos),
      .cout     (cout),
      .bout     (bout),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model: raw sample history per channel, window-based filter.
   int ha[$], hb[$], sa[$], sb[$];
   bit fa, fb, primed;
   int run, pos_m;
   bit [1:0] prev_m;
   bit e_up, e_dn, e_cout, e_bout, e_err;
   int cyc = 0;

   function automatic int gidx(input bit [1:0] v);
      case (v)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic bit settled_m(input int q[$], input bit f);
      for (int i = q.size() - SS; i < q.size(); i++)
         if (q[i] != int'(f)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit accept_m(input int q[$], input bit f);
      if (q.size() < FL) return 1'b0;
      for (int i = q.size() - FL; i < q.size(); i++)
         if (q[i] == int'(f)) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk) cyc++;

   always @(posedge clk or posedge reset) begin
      bit [1:0] abm;
      int d;
      bit st;
      if (reset) begin
         ha.delete(); hb.delete(); sa.delete(); sb.delete();
         for (int i = 0; i < SS; i++) begin
            ha.push_back(0);
            hb.push_back(0);
         end
         fa = 0; fb = 0; primed = 0; run = 0; prev_m = 2'b00; pos_m = 0;
         e_up = 0; e_dn = 0; e_cout = 0; e_bout = 0; e_err = 0;
      end else begin
         abm = {fa, fb};
         e_up = 0; e_dn = 0; e_cout = 0; e_bout = 0; e_err = 0;
         st = settled_m(ha, fa) && settled_m(hb, fb);
         if (!primed) begin
            run = st ? run + 1 : 0;
            if (abm != 2'b00 || run >= FL) begin
               primed = 1;
               prev_m = abm;
            end
         end else begin
            d = (gidx(abm) - gidx(prev_m) + 4) % 4;
            prev_m = abm;
            if (d == 1) begin
               e_up   = 1;
               e_cout = (pos_m == (1 << N) - 1);
               pos_m  = (pos_m + 1) % (1 << N);
            end else if (d == 3) begin
               e_dn   = 1;
               e_bout = (pos_m == 0);
               pos_m  = (pos_m + (1 << N) - 1) % (1 << N);
            end else if (d == 2) begin
               e_err = 1;
            end
         end
         if (clr) begin
            pos_m = 0; e_cout = 0; e_bout = 0;
         end
         sa.push_back(ha[ha.size() - SS]);
         sb.push_back(hb[hb.size() - SS]);
         ha.push_back(int'(ina));
         hb.push_back(int'(inb));
         if (accept_m(sa, fa)) fa = !fa;
         if (accept_m(sb, fb)) fb = !fb;
      end
   end

   // Per-cycle comparison and event counting, sampled after the edge settles.
   int n_up, n_dn, n_err, n_cout, n_bout, first_up_cyc;

   always begin
      @(posedge clk);
      #2;
      check_eq("up_pulse", up_pulse, e_up);
      check_eq("dn_pulse", dn_pulse, e_dn);
      check_eq("cout", cout, e_cout);
      check_eq("bout", bout, e_bout);
      check_eq("err", err, e_err);
      check_eq("pos", pos, pos_m);
      if (up_pulse) begin
         n_up++;
         if (first_up_cyc < 0) first_up_cyc = cyc;
      end
      if (dn_pulse) n_dn++;
      if (err)      n_err++;
      if (cout)     n_cout++;
      if (bout)     n_bout++;
   end

   int drive_cyc;

   task automatic clear_counts();
      n_up = 0; n_dn = 0; n_err = 0; n_cout = 0; n_bout = 0; first_up_cyc = -1;
   endtask

   // Called at a falling edge; holds the new level for exactly 'hold' cycles.
   task automatic step_to(input bit a, input bit b, input int hold);
      ina = a;
      inb = b;
      drive_cyc = cyc;
      repeat (hold) @(negedge clk);
   endtask

   task automatic do_reset(input bit a, input bit b);
      @(negedge clk);
      reset = 1'b1; ina = a; inb = b; clr = 1'b0;
      clear_counts();
      repeat (3) @(negedge clk);
      check_eq("rst_pos", pos, 0);
      check_eq("rst_up", up_pulse, 0);
      reset = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   int t0;

   initial begin
      reset = 1'b1; ina = 1'b0; inb = 1'b0; clr = 1'b0;
      clear_counts();

      // Prime on 11 held through reset release
      do_reset(1'b1, 1'b1);
      check_eq("prime11_no_up", n_up, 0);
      check_eq("prime11_no_dn", n_dn, 0);
      check_eq("prime11_no_err", n_err, 0);
      check_eq("prime11_pos", pos, 0);
      step_to(1'b0, 1'b1, 10);
      check_eq("prime11_then_up", n_up, 1);
      check_eq("prime11_then_no_err", n_err, 0);

      // Full forward cycle with latency measurement
      do_reset(1'b0, 1'b0);
      clear_counts();
      step_to(1'b1, 1'b0, 10);
      t0 = drive_cyc;
      step_to(1'b1, 1'b1, 10);
      step_to(1'b0, 1'b1, 10);
      step_to(1'b0, 1'b0, 10);
      check_eq("fwd_up_count", n_up, 4);
      check_eq("fwd_dn_count", n_dn, 0);
      check_eq("fwd_pos", pos, 4);
      check_eq("fwd_latency", first_up_cyc - (t0 + 1), 5);

      // Borrow then carry across the wrap point
      do_reset(1'b0, 1'b0);
      step_to(1'b0, 1'b1, 10);
      check_eq("wrap_dn", n_dn, 1);
      check_eq("wrap_bout", n_bout, 1);
      check_eq("wrap_pos_max", pos, 255);
      step_to(1'b0, 1'b0, 10);
      check_eq("wrap_up", n_up, 1);
      check_eq("wrap_cout", n_cout, 1);
      check_eq("wrap_pos_zero", pos, 0);

      // Glitch rejection, then minimum-width pulse acceptance
      do_reset(1'b0, 1'b0);
      step_to(1'b1, 1'b0, 2);
      step_to(1'b0, 1'b0, 10);
      check_eq("glitch_no_up", n_up, 0);
      check_eq("glitch_no_err", n_err, 0);
      check_eq("glitch_pos", pos, 0);
      step_to(1'b1, 1'b0, 3);
      step_to(1'b0, 1'b0, 12);
      check_eq("pulse3_up", n_up, 1);
      check_eq("pulse3_dn", n_dn, 1);

      // Simultaneous two-channel change
      do_reset(1'b0, 1'b0);
      step_to(1'b1, 1'b1, 10);
      check_eq("dbl_err", n_err, 1);
      check_eq("dbl_no_up", n_up, 0);
      check_eq("dbl_no_dn", n_dn, 0);
      check_eq("dbl_pos", pos, 0);
      step_to(1'b0, 1'b1, 10);
      check_eq("dbl_next_up", n_up, 1);

      // clr coinciding with an up step at pos=255
      do_reset(1'b0, 1'b0);
      step_to(1'b0, 1'b1, 10);
      check_eq("clr_pre_pos", pos, 255);
      clear_counts();
      step_to(1'b0, 1'b0, 5);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      repeat (8) @(negedge clk);
      check_eq("clr_up", n_up, 1);
      check_eq("clr_no_cout", n_cout, 0);
      check_eq("clr_pos", pos, 0);

      // Random traffic, including occasional clr and one mid-run reset
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < 300; i++) begin
         if (i == 150) begin
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
         end
         clr = ($urandom_range(0, 19) == 0);
         step_to(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(1, 8)));
      end
      clr = 1'b0;
      repeat (10) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
